// File: rtl/dcache_port_arbiter_pkg.sv
// dcache_port_arbiter_pkg
// Shared types for the dcache port arbiter and its in-flight tag FIFO:
//   virt_t / uint32_t : 32-bit address and data words
//   req_kind_e        : which requester owns a dcache request
//   dc_req_t          : one dcache request beat {wr, size, wstrb, addr, wdata}
//   tag_t             : in-flight bookkeeping entry {kind, killed}
package dcache_port_arbiter_pkg;

  typedef logic [31:0] virt_t;
  typedef logic [31:0] uint32_t;

  typedef enum logic {
    REQ_LOAD  = 1'b0,
    REQ_STORE = 1'b1
  } req_kind_e;

  typedef struct packed {
    logic       wr;
    logic [2:0] size;
    logic [3:0] wstrb;
    virt_t      addr;
    uint32_t    wdata;
  } dc_req_t;

  typedef struct packed {
    req_kind_e kind;
    logic      killed;
  } tag_t;

  localparam dc_req_t DC_REQ_IDLE = '{wr: 1'b0, size: 3'b000, wstrb: 4'h0,
                                      addr: 32'h0000_0000, wdata: 32'h0000_0000};

  localparam tag_t TAG_IDLE = '{kind: REQ_LOAD, killed: 1'b0};

  // A flush squashes loads only; store tags pass through untouched.
  function automatic tag_t kill_if_load(input tag_t t, input logic flush);
    tag_t r;
    r = t;
    if (flush && (t.kind == REQ_LOAD)) begin
      r.killed = 1'b1;
    end else begin
      r.killed = t.killed;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_chk.sv
// dcache_port_arbiter_chk
// Simulation checker for the dcache response protocol: data_ok must only
// arrive while at least one request is outstanding.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_dcache_data_ok   : dcache completion strobe
//   i_outstanding_cnt  : arbiter in-flight count
module dcache_port_arbiter_chk #(
  parameter int CW = 3
) (
  input logic          i_clk,
  input logic          i_reset,
  input logic          i_dcache_data_ok,
  input logic [CW-1:0] i_outstanding_cnt
);

  // data_ok with an empty in-flight FIFO is a protocol violation.
  always @(posedge i_clk) begin
    if (!i_reset && i_dcache_data_ok) begin
      assert (i_outstanding_cnt != '0)
        else $error("dcache_data_ok with no outstanding request");
    end
  end

endmodule

// File: rtl/dcache_port_arbiter_inflight_tag_fifo.sv
// inflight_tag_fifo
// In-order FIFO of tags for requests accepted by the dcache but not yet
// completed. A flush marks every load entry as killed.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_push, i_push_tag  : enqueue a tag (ignored when full)
//   i_pop               : dequeue the head (ignored when empty)
//   i_flush_loads       : set killed on every load entry
//   o_head_tag          : oldest entry
//   o_count             : number of valid entries (0..DEPTH)
//   o_full, o_empty     : occupancy flags
module inflight_tag_fifo
  import dcache_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  tag_t                   i_push_tag,
  input  logic                   i_pop,
  input  logic                   i_flush_loads,
  output tag_t                   o_head_tag,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  tag_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_tag = r_mem[r_rd_ptr];
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;

  // Tag storage: flush marking first, then the push overwrites its slot
  // (the pushed tag already carries any same-cycle flush kill).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_IDLE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= kill_if_load(r_mem[i], i_flush_loads);
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_tag;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single dcache request port between the load pipeline and the
// store-buffer commit path. Arbitration is zero-cycle; a request not accepted
// immediately is held (locked) until dcache_addr_ok. Accepted requests are
// tracked in issue order so each in-order data_ok is routed back correctly;
// flushed loads are swallowed.
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_flush                        : pipeline flush (loads only)
//   i_load_*  / o_load_*           : load unit request and response
//   i_store_* / o_store_*          : store buffer commit request and response
//   o_dcache_* / i_dcache_*        : dcache request/response port
//   o_outstanding_cnt              : in-flight request count
//   o_idle                         : nothing in flight, held or requested
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_flush,
  input  logic                             i_load_req,
  input  logic [31:0]                      i_load_addr,
  input  logic [2:0]                       i_load_size,
  output logic                             o_load_addr_ok,
  output logic                             o_load_data_ok,
  output logic [31:0]                      o_load_rdata,
  input  logic                             i_store_req,
  input  logic [3:0]                       i_store_wstrb,
  input  logic [2:0]                       i_store_size,
  input  logic [31:0]                      i_store_addr,
  input  logic [31:0]                      i_store_wdata,
  input  logic                             i_store_pressure,
  output logic                             o_store_addr_ok,
  output logic                             o_store_data_ok,
  output logic                             o_dcache_req,
  output logic                             o_dcache_wr,
  output logic [2:0]                       o_dcache_size,
  output logic [3:0]                       o_dcache_wstrb,
  output logic [31:0]                      o_dcache_addr,
  output logic [31:0]                      o_dcache_wdata,
  input  logic                             i_dcache_addr_ok,
  input  logic                             i_dcache_data_ok,
  input  logic [31:0]                      i_dcache_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] o_outstanding_cnt,
  output logic                             o_idle
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  // Lock / hold state
  logic      r_lock;
  dc_req_t   r_hold;
  req_kind_e r_hold_kind;
  logic      r_hold_killed;
  logic [SW-1:0] r_starve_cnt;

  // Arbitration and request mux
  logic      w_store_win;
  logic      w_load_win;
  logic      w_store_granted;
  dc_req_t   w_dc_req;
  logic      w_dc_valid;
  req_kind_e w_cur_kind;
  logic      w_cur_killed;
  logic      w_accept;
  tag_t      w_push_tag;

  // FIFO side
  tag_t      w_head_tag;
  logic      w_full;
  logic      w_empty;
  logic      w_pop;
  logic [$clog2(MAX_OUTSTANDING):0] w_count;

  // Unlocked arbitration: store wins under pressure, starvation or no load;
  // a load in a flush cycle is never granted; nothing is granted when full.
  always_comb begin
    w_store_win = 1'b0;
    w_load_win  = 1'b0;
    if (!r_lock && !w_full) begin
      if (i_store_req && (i_store_pressure || (r_starve_cnt == STARVE_MAX) || !i_load_req)) begin
        w_store_win = 1'b1;
      end else if (i_load_req && !i_flush) begin
        w_load_win = 1'b1;
      end else begin
        w_store_win = 1'b0;
        w_load_win  = 1'b0;
      end
    end else begin
      w_store_win = 1'b0;
      w_load_win  = 1'b0;
    end
  end

  // Request mux: held request while locked, otherwise the arbitration winner.
  always_comb begin
    w_dc_req     = DC_REQ_IDLE;
    w_dc_valid   = 1'b0;
    w_cur_kind   = REQ_LOAD;
    w_cur_killed = 1'b0;
    if (r_lock) begin
      w_dc_req     = r_hold;
      w_dc_valid   = 1'b1;
      w_cur_kind   = r_hold_kind;
      w_cur_killed = r_hold_killed;
    end else if (w_store_win) begin
      w_dc_req   = '{wr: 1'b1, size: i_store_size, wstrb: i_store_wstrb,
                     addr: i_store_addr, wdata: i_store_wdata};
      w_dc_valid = 1'b1;
      w_cur_kind = REQ_STORE;
    end else if (w_load_win) begin
      w_dc_req   = '{wr: 1'b0, size: i_load_size, wstrb: 4'h0,
                     addr: i_load_addr, wdata: 32'h0000_0000};
      w_dc_valid = 1'b1;
      w_cur_kind = REQ_LOAD;
    end else begin
      w_dc_req   = DC_REQ_IDLE;
      w_dc_valid = 1'b0;
    end
  end

  // Kill state of the current beat includes a flush arriving this cycle,
  // which covers a locked load being flushed while it waits.
  assign w_push_tag = kill_if_load('{kind: w_cur_kind, killed: w_cur_killed}, i_flush);
  assign w_accept   = w_dc_valid && i_dcache_addr_ok;

  assign o_dcache_req   = w_dc_valid;
  assign o_dcache_wr    = w_dc_req.wr;
  assign o_dcache_size  = w_dc_req.size;
  assign o_dcache_wstrb = w_dc_req.wstrb;
  assign o_dcache_addr  = w_dc_req.addr;
  assign o_dcache_wdata = w_dc_req.wdata;

  assign o_load_addr_ok  = w_accept && (w_cur_kind == REQ_LOAD);
  assign o_store_addr_ok = w_accept && (w_cur_kind == REQ_STORE);

  // A stray data_ok with nothing in flight is dropped here.
  assign w_pop           = i_dcache_data_ok && !w_empty;
  assign o_store_data_ok = w_pop && (w_head_tag.kind == REQ_STORE);
  assign o_load_data_ok  = w_pop && (w_head_tag.kind == REQ_LOAD) &&
                           !w_head_tag.killed && !i_flush;
  assign o_load_rdata    = o_load_data_ok ? i_dcache_rdata : 32'h0000_0000;

  assign o_outstanding_cnt = w_count;
  assign o_idle = (w_count == '0) && !r_lock && !i_load_req && !i_store_req;

  // A store waiting in the hold register counts as granted for starvation.
  assign w_store_granted = w_store_win || (r_lock && (r_hold_kind == REQ_STORE));

  // Lock/hold register: capture any presented beat the dcache did not accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lock        <= 1'b0;
      r_hold        <= DC_REQ_IDLE;
      r_hold_kind   <= REQ_LOAD;
      r_hold_killed <= 1'b0;
    end else if (w_dc_valid && !i_dcache_addr_ok) begin
      r_lock        <= 1'b1;
      r_hold        <= w_dc_req;
      r_hold_kind   <= w_cur_kind;
      r_hold_killed <= w_push_tag.killed;
    end else begin
      r_lock        <= 1'b0;
    end
  end

  // Starvation counter: saturating count of cycles a store waits ungranted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (!i_store_req || w_store_granted) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + STARVE_ONE;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  inflight_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_accept),
    .i_push_tag   (w_push_tag),
    .i_pop        (w_pop),
    .i_flush_loads(i_flush),
    .o_head_tag   (w_head_tag),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam logic [31:0] LA = 32'h1000_0040;
  localparam logic [31:0] SA = 32'h2000_0080;
  localparam logic [31:0] SD = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        load_req, store_req, store_pressure;
  logic [31:0] load_addr, store_addr, store_wdata, dcache_rdata;
  logic [2:0]  load_size, store_size;
  logic [3:0]  store_wstrb;
  logic        dcache_addr_ok, dcache_data_ok;
  logic        load_addr_ok, load_data_ok, store_addr_ok, store_data_ok;
  logic [31:0] load_rdata, dcache_addr, dcache_wdata;
  logic        dcache_req, dcache_wr, idle;
  logic [2:0]  dcache_size;
  logic [3:0]  dcache_wstrb;
  logic [2:0]  outstanding_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_load_req(load_req), .i_load_addr(load_addr), .i_load_size(load_size),
    .o_load_addr_ok(load_addr_ok), .o_load_data_ok(load_data_ok), .o_load_rdata(load_rdata),
    .i_store_req(store_req), .i_store_wstrb(store_wstrb), .i_store_size(store_size),
    .i_store_addr(store_addr), .i_store_wdata(store_wdata), .i_store_pressure(store_pressure),
    .o_store_addr_ok(store_addr_ok), .o_store_data_ok(store_data_ok),
    .o_dcache_req(dcache_req), .o_dcache_wr(dcache_wr), .o_dcache_size(dcache_size),
    .o_dcache_wstrb(dcache_wstrb), .o_dcache_addr(dcache_addr), .o_dcache_wdata(dcache_wdata),
    .i_dcache_addr_ok(dcache_addr_ok), .i_dcache_data_ok(dcache_data_ok),
    .i_dcache_rdata(dcache_rdata), .o_outstanding_cnt(outstanding_cnt), .o_idle(idle)
  );

  dcache_port_arbiter_chk #(.CW(3)) u_chk (
    .i_clk(clk), .i_reset(reset), .i_dcache_data_ok(dcache_data_ok),
    .i_outstanding_cnt(outstanding_cnt)
  );

  typedef struct packed {
    logic        ld, st, pr, fl, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_wr, e_laok, e_saok, e_ldok, e_sdok;
    logic [2:0]  e_cnt;
    logic        e_idle;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic ld, st, pr, fl, aok, dok, input logic [31:0] rd,
                              input logic req, wr, laok, saok, ldok, sdok,
                              input logic [2:0] cnt, input logic idl);
    vec_t v;
    v = '{ld, st, pr, fl, aok, dok, rd, req, wr, laok, saok, ldok, sdok, cnt, idl};
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, st, pr, fl, aok, dok);
    load_req       = ld;
    store_req      = st;
    store_pressure = pr;
    flush          = fl;
    dcache_addr_ok = aok;
    dcache_data_ok = dok;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    load_addr = LA; load_size = 3'd2;
    store_addr = SA; store_wdata = SD; store_wstrb = 4'hF; store_size = 3'd2;
    dcache_rdata = 32'h0;

    //          ld    st    pr    fl    aok   dok   rdata         req   wr    laok  saok  ldok  sdok  cnt   idle
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h9999_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    tick(); tick();
    reset = 1'b0;

    // Table-driven single-cycle vectors applied back to back from reset.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ld, vecs[i].st, vecs[i].pr, vecs[i].fl, vecs[i].aok, vecs[i].dok);
      dcache_rdata = vecs[i].rdata;
      @(negedge clk);
      chk1($sformatf("v%0d_req", i), dcache_req, vecs[i].e_req);
      chk1($sformatf("v%0d_laok", i), load_addr_ok, vecs[i].e_laok);
      chk1($sformatf("v%0d_saok", i), store_addr_ok, vecs[i].e_saok);
      chk1($sformatf("v%0d_ldok", i), load_data_ok, vecs[i].e_ldok);
      chk1($sformatf("v%0d_sdok", i), store_data_ok, vecs[i].e_sdok);
      chk32($sformatf("v%0d_cnt", i), {29'b0, outstanding_cnt}, {29'b0, vecs[i].e_cnt});
      chk1($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
      if (vecs[i].e_req) begin
        chk1($sformatf("v%0d_wr", i), dcache_wr, vecs[i].e_wr);
        chk32($sformatf("v%0d_addr", i), dcache_addr, vecs[i].e_wr ? SA : LA);
        chk32($sformatf("v%0d_wdata", i), dcache_wdata, vecs[i].e_wr ? SD : 32'h0);
        chk32($sformatf("v%0d_wstrb", i), {28'b0, dcache_wstrb}, vecs[i].e_wr ? 32'hF : 32'h0);
      end
      if (vecs[i].e_ldok) begin
        chk32($sformatf("v%0d_rdata", i), load_rdata, vecs[i].rdata);
      end
      tick();
    end

    // Starvation: 8 load grants, then the store takes the 9th slot.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, (i > 0) ? 1'b1 : 1'b0);
      @(negedge clk);
      chk1($sformatf("starve_wr_%0d", i), dcache_wr, (i == 8) ? 1'b1 : 1'b0);
      chk1($sformatf("starve_laok_%0d", i), load_addr_ok, (i < 8) ? 1'b1 : 1'b0);
      chk1($sformatf("starve_saok_%0d", i), store_addr_ok, (i == 8) ? 1'b1 : 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk1("starve_cleared_wr", dcache_wr, 1'b0);
    chk1("starve_cleared_laok", load_addr_ok, 1'b1);
    chk1("starve_store_done", store_data_ok, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dcache_rdata = 32'hABCD_0009;
    @(negedge clk);
    chk1("starve_drain_ldok", load_data_ok, 1'b1);
    chk32("starve_drain_rdata", load_rdata, 32'hABCD_0009);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk32("starve_end_cnt", {29'b0, outstanding_cnt}, 32'd0);
    tick();

    // Lock: address held stable for 3 cycles after the source drops.
    load_addr = 32'h0000_1234;
    for (int c = 0; c < 4; c++) begin
      drive((c == 0) ? 1'b1 : 1'b0, (c == 1 || c == 2) ? 1'b1 : 1'b0,
            (c == 1 || c == 2) ? 1'b1 : 1'b0, 1'b0, (c == 3) ? 1'b1 : 1'b0, 1'b0);
      if (c > 0) load_addr = 32'hDEAD_0000;
      @(negedge clk);
      chk1($sformatf("lock_req_%0d", c), dcache_req, 1'b1);
      chk1($sformatf("lock_wr_%0d", c), dcache_wr, 1'b0);
      chk32($sformatf("lock_addr_%0d", c), dcache_addr, 32'h0000_1234);
      chk1($sformatf("lock_laok_%0d", c), load_addr_ok, (c == 3) ? 1'b1 : 1'b0);
      chk1($sformatf("lock_saok_%0d", c), store_addr_ok, 1'b0);
      tick();
    end
    load_addr = LA;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dcache_rdata = 32'h5A5A_A5A5;
    @(negedge clk);
    chk1("lock_ldok", load_data_ok, 1'b1);
    chk32("lock_rdata", load_rdata, 32'h5A5A_A5A5);
    tick();

    // Flush with two loads and one store outstanding.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk1("flush_store_saok", store_addr_ok, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk32("flush_cnt3", {29'b0, outstanding_cnt}, 32'd3);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk1($sformatf("flush_ldok_%0d", k), load_data_ok, 1'b0);
      chk1($sformatf("flush_sdok_%0d", k), store_data_ok, (k == 2) ? 1'b1 : 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk32("flush_end_cnt", {29'b0, outstanding_cnt}, 32'd0);
    tick();

    // FIFO full: 4 loads in flight block the 5th until a slot frees.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk1($sformatf("full_laok_%0d", i), load_addr_ok, 1'b1);
      tick();
    end
    @(negedge clk);
    chk1("full_noreq", dcache_req, 1'b0);
    chk32("full_cnt4", {29'b0, outstanding_cnt}, 32'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk1("full_pop_noreq", dcache_req, 1'b0);
    chk1("full_pop_ldok", load_data_ok, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk32("full_cnt3", {29'b0, outstanding_cnt}, 32'd3);
    chk1("full_regrant_req", dcache_req, 1'b1);
    chk1("full_regrant_laok", load_addr_ok, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk1($sformatf("full_drain_%0d", i), load_data_ok, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("full_end_idle", idle, 1'b1);
    tick();

    // Reset with two outstanding and a locked load.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick(); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("prerst_locked_req", dcache_req, 1'b1);
    chk32("prerst_cnt2", {29'b0, outstanding_cnt}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_req", dcache_req, 1'b0);
    chk32("rst_cnt", {29'b0, outstanding_cnt}, 32'd0);
    chk1("rst_idle", idle, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Shares the single dcache request port between the load pipeline and the store-buffer commit path.
- Picks one requester per request slot and holds that choice stable until the dcache accepts it.
- Tracks outstanding requests in issue order, so each in-order dcache_data_ok goes back to the right requester.
- On pipeline flush, swallows responses for squashed loads; committed stores are never affected.
- Sits between the execute-stage load unit / store buffer and the dcache.

Parameters:
MAX_OUTSTANDING, 4, depth of the in-flight tag FIFO (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles a store may wait before it overrides load priority

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush; squashes loads only
load_req  in  1  load request valid; held until load_addr_ok unless flushed
load_addr  in  32  load virtual address
load_size  in  3  load size code
load_addr_ok  out  1  load request accepted by dcache
load_data_ok  out  1  load data returned (not pulsed for killed loads)
load_rdata  out  32  load data, valid with load_data_ok
store_req  in  1  store commit request; held until store_addr_ok
store_wstrb  in  4  byte strobes
store_size  in  3  store size code
store_addr  in  32  store address
store_wdata  in  32  store data
store_pressure  in  1  store buffer full; stores take priority
store_addr_ok  out  1  store accepted by dcache
store_data_ok  out  1  store completion
dcache_req  out  1  request valid
dcache_wr  out  1  1 = store, 0 = load
dcache_size  out  3  size code
dcache_wstrb  out  4  strobes (0 for loads)
dcache_addr  out  32  address
dcache_wdata  out  32  write data (0 for loads)
dcache_addr_ok  in  1  request accepted this cycle
dcache_data_ok  in  1  oldest outstanding request complete
dcache_rdata  in  32  read data
outstanding_cnt  out  $clog2(MAX_OUTSTANDING)+1  number of in-flight requests
idle  out  1  no in-flight request, no held request, no request pending

Behaviour:
Reset values:
- All *_ok outputs, dcache_req, lock, FIFO pointers, outstanding_cnt and the starvation counter reset to 0.
- idle resets to 1.

Arbitration (unlocked cycle):
- Store wins if store_req && (store_pressure || starve_cnt==STARVE_LIMIT || !load_req).
- Otherwise load wins if load_req.
- A load presented in the same cycle as flush is not granted.
- No grant when the FIFO is full (outstanding_cnt==MAX_OUTSTANDING).

Lock / hold register:
- If a grant is issued and dcache_addr_ok=0, next cycle lock=1 and the hold register captures {wr, size, wstrb, addr, wdata, kind}.
- While locked, dcache_* outputs come from the hold register and dcache_req stays 1, regardless of flush or source deassertion. Lock clears on dcache_addr_ok.

Acceptance:
- dcache_addr_ok with dcache_req=1 pulses load_addr_ok or store_addr_ok for the granted kind, in the same cycle.
- The same event pushes a tag {kind, killed} into the FIFO.
- killed=1 if the entry is a load and flush is asserted that cycle, or if the held load was flushed while locked.

Response:
- dcache_data_ok pops the FIFO head.
- Store head: store_data_ok=1.
- Load head, not killed: load_data_ok=1 and load_rdata=dcache_rdata (combinational pass-through).
- Load head, killed: both data_ok outputs stay 0.
- data_ok with an empty FIFO is a protocol violation; it is asserted against in simulation and ignored in RTL.

Flush:
- Sets killed on every load entry in the FIFO and on a locked load.
- Store entries are untouched.
- A flush on the same cycle as a load pop suppresses that load_data_ok.

Counters:
- Push and pop in the same cycle leave outstanding_cnt unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- starve_cnt increments, saturating at STARVE_LIMIT, on each cycle store_req=1 and the store is not granted.
- starve_cnt clears on store grant or when store_req=0.

Latency:
- Arbitration is zero-cycle: source req to dcache_req in the same cycle when unlocked.
- Response is combinational from dcache_data_ok.

Decomposition:
- Shared package (cpu.svh): virt_t, uint32_t, a req_kind_e enum (REQ_LOAD, REQ_STORE), and a dc_req_t struct {wr, size, wstrb, addr, wdata}.
- One sub-module, inflight_tag_fifo: parameterised depth, push/pop, a flush_loads input that sets killed on load entries, count/full/empty outputs.

Test Plan:
- Only store_req, dcache_addr_ok=1 every cycle, data_ok 2 cycles later -> dcache_wr=1 and store_addr_ok the same cycle; store_data_ok after 2 cycles; outstanding_cnt goes 1 then 0.
- load_req and store_req together, store_pressure=0 -> load granted for 8 cycles (starve_cnt 0..8); 9th cycle store granted; starve_cnt returns to 0.
- Load granted with dcache_addr_ok held 0 for 3 cycles, load_req dropped after cycle 1 -> dcache_req and address held stable 3 cycles; load_addr_ok on the 4th.
- Two loads and one store outstanding, flush, then 3 data_ok -> load_data_ok never asserts, store_data_ok asserts once, outstanding_cnt returns to 0.
- Issue 4 loads with no data_ok (MAX_OUTSTANDING=4) -> 5th request gets no dcache_req; one data_ok frees a slot and the next cycle grants.
- reset asserted with 2 outstanding and a lock -> next cycle dcache_req=0, outstanding_cnt=0, idle=1.
